// File: rtl/rr_arb_8to1_pkg.sv
// Shared definitions for the rr_arb_8to1 arbiter: state encoding, sizes and the grant encoder.
package rr_arb_8to1_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] onehot_sel(input logic [SEL_W-1:0] idx);
        return 8'd1 << idx;
    endfunction

endpackage

// File: rtl/rr_arb_8to1_mux.sv
// mux_8to1: N-bit 8:1 data mux used as the arbiter's shared datapath.
module mux_8to1 #(
    parameter int N = 4
) (
    input  logic [N-1:0] X0,
    input  logic [N-1:0] X1,
    input  logic [N-1:0] X2,
    input  logic [N-1:0] X3,
    input  logic [N-1:0] X4,
    input  logic [N-1:0] X5,
    input  logic [N-1:0] X6,
    input  logic [N-1:0] X7,
    input  logic [2:0]   S,
    output logic [N-1:0] Z
);

    // Select one requester word by index.
    always_comb begin
        Z = X0;
        case (S)
            3'd0:    Z = X0;
            3'd1:    Z = X1;
            3'd2:    Z = X2;
            3'd3:    Z = X3;
            3'd4:    Z = X4;
            3'd5:    Z = X5;
            3'd6:    Z = X6;
            3'd7:    Z = X7;
            default: Z = X0;
        endcase
    end

endmodule

// File: rtl/rr_arb_8to1.sv
// rr_arb_8to1: round-robin arbiter granting one of eight requesters onto a shared N-bit mux.
// Define RR_ARB_FIXED_PRIO_EN to pin the priority pointer at 0 (fixed priority, requester 0 highest).
module rr_arb_8to1
    import rr_arb_8to1_pkg::*;
#(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [N-1:0]       X0,
    input  logic [N-1:0]       X1,
    input  logic [N-1:0]       X2,
    input  logic [N-1:0]       X3,
    input  logic [N-1:0]       X4,
    input  logic [N-1:0]       X5,
    input  logic [N-1:0]       X6,
    input  logic [N-1:0]       X7,
    input  logic               out_ready,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic [N-1:0]       Z,
    output logic               out_valid,
    output logic               xfer
);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic               out_valid_q, out_valid_d;
    logic               win_found_s;
    logic [SEL_W-1:0]   win_idx_s;
    logic [SEL_W-1:0]   scan_idx_s;

    // Winner scan: first requesting index starting at ptr, wrapping modulo 8.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {SEL_W{1'b0}};
        scan_idx_s  = {SEL_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx_s = ptr_q + SEL_W'(k);
            if (!win_found_s && req[scan_idx_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = scan_idx_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state logic; a transfer takes precedence over a withdrawn request.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_found_s) begin
                    state_d     = ARB_GRANT;
                    sel_d       = win_idx_s;
                    gnt_d       = onehot_sel(win_idx_s);
                    out_valid_d = 1'b1;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (out_ready) begin
                    state_d     = ARB_IDLE;
                    ptr_d       = sel_q + 3'd1;
                    gnt_d       = {NUM_REQ{1'b0}};
                    out_valid_d = 1'b0;
                end else if (!req[sel_q]) begin
                    state_d     = ARB_IDLE;
                    gnt_d       = {NUM_REQ{1'b0}};
                    out_valid_d = 1'b0;
                end else begin
                    state_d = ARB_GRANT;
                end
            end
            default: begin
                state_d     = ARB_IDLE;
                gnt_d       = {NUM_REQ{1'b0}};
                sel_d       = {SEL_W{1'b0}};
                ptr_d       = {SEL_W{1'b0}};
                out_valid_d = 1'b0;
            end
        endcase
`ifdef RR_ARB_FIXED_PRIO_EN
        ptr_d = {SEL_W{1'b0}};
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= {NUM_REQ{1'b0}};
            sel_q       <= {SEL_W{1'b0}};
            ptr_q       <= {SEL_W{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
        end
    end

    mux_8to1 #(.N(N)) u_mux (
        .X0(X0), .X1(X1), .X2(X2), .X3(X3),
        .X4(X4), .X5(X5), .X6(X6), .X7(X7),
        .S (sel_q),
        .Z (Z)
    );

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign xfer      = out_valid_q & out_ready;

endmodule
